// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO read-side stream path: the output buffer state
// encoding (which doubles as the word count) and the buffer depth.
package fifo_stream_pkg;

  // Encoding equals the number of words held, so it maps straight onto level.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } buf_state_t;

  localparam int unsigned BUF_DEPTH = 2;

  // Word count held in the buffer for a given state.
  function automatic logic [1:0] state_level(input buf_state_t s);
    return s;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-slot in-order buffer with registered state. The write side (push) and
// read side (pop) are independent; the state tracks occupancy so the caller
// can stop pushing when full without looking at the read side.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  valid,
  output logic                  full,
  output buf_state_t            state
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] slot_q [BUF_DEPTH];
  logic [PtrW-1:0]       head_q, head_d;
  logic [PtrW-1:0]       tail_q, tail_d;
  buf_state_t            state_q, state_d;
  logic                  push_ok, pop_ok;

  // Ignore requests the current occupancy cannot honour.
  assign push_ok = push && (state_q != S_FULL);
  assign pop_ok  = pop && (state_q != S_EMPTY);

  // Occupancy and pointer next-state.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push_ok) tail_d = tail_q + PtrW'(1);
    if (pop_ok)  head_d = head_q + PtrW'(1);
    case (state_q)
      S_EMPTY: begin
        if (push_ok) state_d = S_ONE;
      end
      S_ONE: begin
        if (push_ok && !pop_ok)      state_d = S_FULL;
        else if (pop_ok && !push_ok) state_d = S_EMPTY;
      end
      S_FULL: begin
        if (pop_ok) state_d = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Slot storage; a push writes the tail slot at the same edge the FIFO pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) slot_q[i] <= '0;
    end else if (push_ok) begin
      slot_q[tail_q] <= wdata;
    end
  end

  // Outputs come only from registers: no path from push/pop/wdata.
  assign rdata = slot_q[head_q];
  assign valid = (state_q != S_EMPTY);
  assign full  = (state_q == S_FULL);
  assign state = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side consumer: pops narrow words into a 2-entry buffer whenever
// there is room, and presents them on a registered valid/ready stream.
// rd never depends on m_ready, so downstream back-pressure has no
// combinational path to the FIFO pop strobe.
// Optional statistics counters: define FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            level
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic [CNT_WIDTH-1:0]  stall_cycles
`endif
);

  if (CNT_WIDTH == 0 || DATA_WIDTH == 0) begin : g_bad_width
    $error("fifo_rd_stream: DATA_WIDTH and CNT_WIDTH must be non-zero");
  end

  logic       buf_full;
  logic       pop;
  buf_state_t buf_state;

  // Pop the FIFO whenever it has data and the buffer has a free slot.
  assign rd  = ~empty && !buf_full;
  assign pop = m_valid && m_ready;

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (clk),
    .reset(reset),
    .push (rd),
    .wdata(r_data),
    .pop  (pop),
    .rdata(m_data),
    .valid(m_valid),
    .full (buf_full),
    .state(buf_state)
  );

  assign level = state_level(buf_state);

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] words_q, stall_q;

  // Accepted-word and back-pressure counters; both wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop)                 words_q <= words_q + CNT_WIDTH'(1);
      if (m_valid && !m_ready) stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign words_out    = words_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream. The FIFO is modelled as a queue of words and the
// output buffer as a queue of at most two words; expected outputs follow
// from queue sizes and heads each cycle.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          empty;
  logic [DW-1:0] r_data;
  logic          rd;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    level;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CW-1:0] words_out;
  logic [CW-1:0] stall_cycles;
`endif

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .empty  (empty),
    .r_data (r_data),
    .rd     (rd),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .level  (level)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .words_out   (words_out),
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] src_q [$];   // words waiting in the FIFO
  logic [DW-1:0] obuf_q [$];  // words held by the output buffer
  logic [DW-1:0] out_log [$]; // words accepted downstream
  int unsigned   exp_words, exp_stalls;

  logic          last_rd, last_valid;
  logic [DW-1:0] last_data;
  logic [1:0]    last_level;
  logic          prev_hold;   // previous cycle had valid && !ready
  logic [DW-1:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    empty  = (src_q.size() == 0);
    r_data = (src_q.size() == 0) ? '0 : src_q[0];
  endtask

  // Per-cycle comparison of all outputs against the queue model.
  task automatic compare();
    logic          exp_rd;
    logic [1:0]    exp_level;
    exp_rd    = (src_q.size() > 0) && (obuf_q.size() < 2);
    exp_level = 2'(obuf_q.size());
    check("rd", 32'(rd), 32'(exp_rd));
    check("m_valid", 32'(m_valid), 32'(obuf_q.size() > 0));
    check("level", 32'(level), 32'(exp_level));
    if (obuf_q.size() > 0) check("m_data", 32'(m_data), 32'(obuf_q[0]));
    if (prev_hold) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(prev_data));
    end
`ifdef FIFO_RD_STREAM_STATS_EN
    check("words_out", 32'(words_out), 32'(CW'(exp_words)));
    check("stall_cycles", 32'(stall_cycles), 32'(CW'(exp_stalls)));
`endif
    last_rd    = rd;
    last_valid = m_valid;
    last_data  = m_data;
    last_level = level;
  endtask

  // One clock: drive, compare, advance the model at the edge.
  task automatic cycle(input logic rdy);
    logic do_push, do_pop;
    m_ready = rdy;
    drive_fifo();
    #1;
    compare();
    do_push   = (src_q.size() > 0) && (obuf_q.size() < 2);
    do_pop    = (obuf_q.size() > 0) && rdy;
    prev_hold = (obuf_q.size() > 0) && !rdy;
    prev_data = m_data;
    if (do_pop) out_log.push_back(m_data);
    @(posedge clk);
    if (do_pop) begin
      void'(obuf_q.pop_front());
      exp_words++;
    end
    if (prev_hold) exp_stalls++;
    if (do_push) obuf_q.push_back(src_q.pop_front());
    #2;
  endtask

  task automatic model_reset();
    obuf_q.delete();
    exp_words  = 0;
    exp_stalls = 0;
    prev_hold  = 1'b0;
  endtask

  initial begin
    int rd_run;
    int rd_max;
    reset   = 1'b1;
    m_ready = 1'b0;
    model_reset();
    out_log.delete();
    drive_fifo();

    // Reset state with an empty FIFO.
    #12;
    check("t1_rst_rd", 32'(rd), 32'd0);
    check("t1_rst_valid", 32'(m_valid), 32'd0);
    check("t1_rst_level", 32'(level), 32'd0);
    check("t1_rst_data", 32'(m_data), 32'd0);
    reset = 1'b0;
    #5;

    // First word: rd in the same cycle, visible one cycle later.
    src_q.push_back(8'hA5);
    cycle(1'b1);
    check("t1_rd", 32'(last_rd), 32'd1);
    cycle(1'b1);
    check("t1_valid", 32'(last_valid), 32'd1);
    check("t1_data", 32'(last_data), 32'hA5);
    check("t1_level", 32'(last_level), 32'd1);
    cycle(1'b1);

    // Back-pressure: two words taken, third left in the FIFO.
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    for (int i = 0; i < 4; i++) cycle(1'b0);
    m_ready = 1'b0;
    drive_fifo();
    #1;
    check("t2_rd_blocked", 32'(rd), 32'd0);
    check("t2_level", 32'(level), 32'd2);
    check("t2_data", 32'(m_data), 32'h11);
    check("t2_left", 32'(src_q.size()), 32'd1);
    @(posedge clk);
    #2;

    // Release back-pressure: drains in order.
    out_log.delete();
    for (int i = 0; i < 5; i++) cycle(1'b1);
    check("t3_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      check("t3_w0", 32'(out_log[0]), 32'h11);
      check("t3_w1", 32'(out_log[1]), 32'h22);
      check("t3_w2", 32'(out_log[2]), 32'h33);
    end
    check("t3_level", 32'(last_level), 32'd0);

    // Steady stream: rd high for 8 consecutive cycles, one word per clock.
    out_log.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h40 + i));
    rd_run = 0;
    rd_max = 0;
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1);
      rd_run = last_rd ? rd_run + 1 : 0;
      if (rd_run > rd_max) rd_max = rd_run;
    end
    check("t4_rd_run", 32'(rd_max), 32'd8);
    check("t4_count", 32'(out_log.size()), 32'd8);
    if (out_log.size() == 8) check("t4_last", 32'(out_log[7]), 32'h47);

    // Asynchronous reset while full.
    src_q.push_back(8'h61);
    src_q.push_back(8'h62);
    src_q.push_back(8'h63);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    check("t5_pre_level", 32'(last_level), 32'd2);
    reset = 1'b1;
    #1;
    check("t5_valid", 32'(m_valid), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    model_reset();
    #3;
    reset = 1'b0;
    out_log.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1);
    check("t5_count", 32'(out_log.size()), 32'd1);
    if (out_log.size() == 1) check("t5_word", 32'(out_log[0]), 32'h63);

`ifdef FIFO_RD_STREAM_STATS_EN
    // Counters: 5 words, 3 stalled cycles while valid.
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(8'(8'h80 + i));
    cycle(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1);
    drive_fifo();
    #1;
    check("t6_words", 32'(words_out), 32'd5);
    check("t6_stalls", 32'(stall_cycles), 32'd3);
    @(posedge clk);
    #2;
`endif

    // Randomised traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0 && src_q.size() < 6) src_q.push_back(8'($urandom));
      cycle($urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 12; i++) cycle(1'b1);
    check("drain_level", 32'(last_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
